// File: rtl/madd_loader.sv
// madd_loader: decodes a host byte stream into LOAD/RUN strobes for a multi-MAC.
// Define MADD_LOADER_FIFO_EN for a 4-entry input FIFO; otherwise a single-entry register buffers input.
module madd_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load,
    output logic       run,
    output logic [1:0] insn,
    output logic [3:0] index,
    output logic [3:0] data,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, HDR, LOAD, RUN} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_fin;
    logic       r_rdy_en;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;

    // HDR is only entered with a non-empty buffer; r_fin marks the cycle showing the last load beat
    assign w_pop    = (r_state == HDR) || (r_state == LOAD && !r_fin && !w_empty);
    assign in_ready = r_rdy_en && (!w_full || w_pop);
    assign w_push   = in_valid && in_ready;
    assign busy     = (r_state != IDLE) || !w_empty;

`ifdef MADD_LOADER_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_count;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_head  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= w_push ? r_wp + 2'd1 : r_wp;
            r_rp    <= w_pop ? r_rp + 2'd1 : r_rp;
            r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
        end
    end
`else
    logic [7:0] r_buf;
    logic       r_full;

    assign w_empty = !r_full;
    assign w_full  = r_full;
    assign w_head  = r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_full <= 1'b0;
        end else begin
            r_buf  <= w_push ? in_data : r_buf;
            r_full <= w_push || (r_full && !w_pop);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_fin    <= 1'b0;
            r_rdy_en <= 1'b0;
            load     <= 1'b0;
            run      <= 1'b0;
            insn     <= '0;
            index    <= '0;
            data     <= '0;
            done     <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            load     <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                IDLE: r_state <= w_empty ? IDLE : HDR;
                HDR: begin
                    case (w_head[7:6])
                        2'b01: begin
                            insn    <= w_head[5:4];
                            r_cnt   <= w_head[3:0];
                            r_state <= LOAD;
                        end
                        2'b10: begin
                            insn    <= w_head[5:4];
                            r_cnt   <= w_head[3:0];
                            run     <= 1'b1;
                            r_state <= RUN;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                LOAD: begin
                    if (r_fin) begin
                        r_fin   <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else if (!w_empty) begin
                        load  <= 1'b1;
                        index <= w_head[7:4];
                        data  <= w_head[3:0];
                        r_fin <= (r_cnt == 4'd0);
                        r_cnt <= (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
                    end
                end
                RUN: begin
                    if (r_cnt == 4'd0) begin
                        run     <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_madd_loader.sv
// tb_madd_loader: directed stimulus with an ordered scoreboard of expected load/run/done events.
module tb_madd_loader;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       load;
    logic       run;
    logic [1:0] insn;
    logic [3:0] index;
    logic [3:0] data;
    logic       busy;
    logic       done;

    madd_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .load(load), .run(run), .insn(insn),
        .index(index), .data(data), .busy(busy), .done(done)
    );

    typedef struct {
        logic [1:0] k;
        logic [1:0] ins;
        logic [3:0] idx;
        logic [3:0] dat;
    } ev_t;

    localparam logic [1:0] K_L = 2'd0;
    localparam logic [1:0] K_R = 2'd1;
    localparam logic [1:0] K_D = 2'd2;
`ifdef MADD_LOADER_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    ev_t        q[$];
    ev_t        m_e;
    logic [1:0] m_k;
    int         n_chk = 0;
    int         n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_load(input logic [1:0] ins, input logic [7:0] p);
        q.push_back('{K_L, ins, p[7:4], p[3:0]});
    endfunction

    function automatic void exp_done();
        q.push_back('{K_D, 2'd0, 4'd0, 4'd0});
    endfunction

    function automatic void exp_run(input logic [7:0] h);
        for (int i = 0; i <= int'(h[3:0]); i++) q.push_back('{K_R, h[5:4], 4'd0, 4'd0});
        exp_done();
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl", {31'd0, load & run}, 32'd0);
            if (load || run || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_evt", {29'd0, load, run, done}, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    m_k = done ? K_D : (run ? K_R : K_L);
                    chk("evt_kind", {30'd0, m_k}, {30'd0, m_e.k});
                    if (m_e.k == K_L) begin
                        chk("index", {28'd0, index}, {28'd0, m_e.idx});
                        chk("data", {28'd0, data}, {28'd0, m_e.dat});
                        chk("insn_load", {30'd0, insn}, {30'd0, m_e.ins});
                    end
                    if (m_e.k == K_R) chk("insn_run", {30'd0, insn}, {30'd0, m_e.ins});
                end
            end
        end
    end

    // Called right after a negedge; returns right after the negedge following the transfer.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_queue", q.size(), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] fb [6];
        int acc;
        int acc8;
        int cyc;
        fb = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'h81, 8'h91};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outs", {22'd0, load, run, insn, index, data, done, busy, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_clk", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_clk", {31'd0, in_ready}, 32'd1);

        // LOAD burst of three back-to-back payloads
        send(8'h42);
        exp_load(2'd0, 8'h3A); send(8'h3A);
        exp_load(2'd0, 8'h5B); send(8'h5B);
        exp_load(2'd0, 8'h7C); send(8'h7C);
        exp_done();
        drain();
        chk("hold_index_a", {28'd0, index}, 32'd7);
        chk("hold_data_a", {28'd0, data}, 32'hC);

        // RUN for four cycles with insn=1
        exp_run(8'h93);
        send(8'h93);
        drain();
        chk("insn_hold", {30'd0, insn}, 32'd1);
        chk("hold_index_b", {28'd0, index}, 32'd7);
        chk("hold_data_b", {28'd0, data}, 32'hC);

        // LOAD (N=2) with payloads separated by idle gaps
        send(8'h41);
        repeat (5) @(negedge clk);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        exp_load(2'd0, 8'h2F); send(8'h2F);
        repeat (5) @(negedge clk);
        chk("stall_load", {31'd0, load}, 32'd0);
        chk("stall_index", {28'd0, index}, 32'd2);
        chk("stall_data", {28'd0, data}, 32'hF);
        exp_load(2'd0, 8'h3E); send(8'h3E);
        exp_done();
        drain();

        // Two NOPs then a single-cycle RUN
        send(8'h00);
        send(8'hC5);
        exp_run(8'h80);
        send(8'h80);
        drain();
        chk("insn_after_nop_run", {30'd0, insn}, 32'd0);

        // Hold in_valid across a long RUN: buffer fills to its depth, then all bytes land in order
        exp_run(8'h8F);
        send(8'h8F);
        cyc = 0;
        while (!run && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_started", {31'd0, run}, 32'd1);
        for (int i = 0; i < 6; i++) exp_run(fb[i]);
        acc = 0; acc8 = 0; cyc = 0;
        in_valid = 1'b1;
        in_data  = fb[0];
        while (acc < 6 && cyc < 400) begin
            if (in_ready) acc++;
            @(negedge clk);
            cyc++;
            if (cyc == 8) acc8 = acc;
            if (acc < 6) in_data = fb[acc];
        end
        in_valid = 1'b0;
        chk("buffer_fill", acc8, DEPTH);
        chk("all_accepted", acc, 32'd6);
        drain();

        // Reset in the middle of a LOAD burst
        send(8'h47);
        exp_load(2'd0, 8'h12); send(8'h12);
        exp_load(2'd0, 8'h34); send(8'h34);
        repeat (4) @(negedge clk);
        chk("mid_queue", q.size(), 32'd0);
        rst_n = 1'b0;
        #1 chk("mid_reset_outs", {22'd0, load, run, insn, index, data, done, busy, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_run(8'h81);
        send(8'h81);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
